// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back drain buffer (wb_drain).
package wb_pkg;

  localparam int REG_AW    = 4;
  localparam int NUM_REGS  = 16;
  // Widest DATAWIDTH the shared entry type can carry; narrower data is zero-extended.
  localparam int WB_DATA_W = 64;

  // One buffered register-file write. The destination field is called rd
  // because "reg" is a reserved word.
  typedef struct packed {
    logic [REG_AW-1:0]    rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  // One-hot decode of a register index into the pending vector.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] r);
    logic [NUM_REGS-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/wb_fifo2.sv
// Two-in / two-out circular FIFO of wb_entry_t. Up to two pushes and two pops
// per cycle; exposes the two oldest entries, the occupancy and per-slot valid.
module wb_fifo2 import wb_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                push_cnt,
  input  wb_entry_t                 push0,
  input  wb_entry_t                 push1,
  input  logic [1:0]                pop_cnt,
  output wb_entry_t                 head0,
  output wb_entry_t                 head1,
  output logic [$clog2(DEPTH):0]    count,
  output logic [DEPTH-1:0]          valid,
  output logic [DEPTH*REG_AW-1:0]   regs
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd1_s, wr1_s;

  assign rd1_s = rd_q + PTR_ONE;
  assign wr1_s = wr_q + PTR_ONE;
  assign head0 = mem_q[rd_q];
  assign head1 = mem_q[rd1_s];
  assign count = count_q;
  assign valid = valid_q;

  // Flatten the destination index of every slot for the pending decode.
  always_comb begin
    regs = '0;
    for (int i = 0; i < DEPTH; i++) begin
      regs[i*REG_AW +: REG_AW] = mem_q[i].rd;
    end
  end

  // Next-state: retire popped slots first, then fill pushed slots. Ready
  // throttling upstream guarantees pushes never land on a slot still occupied.
  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    case (pop_cnt)
      2'd1: valid_d[rd_q] = 1'b0;
      2'd2: begin
        valid_d[rd_q]  = 1'b0;
        valid_d[rd1_s] = 1'b0;
      end
      default: valid_d = valid_q;
    endcase
    case (push_cnt)
      2'd1: begin
        mem_d[wr_q]   = push0;
        valid_d[wr_q] = 1'b1;
      end
      2'd2: begin
        mem_d[wr_q]    = push0;
        valid_d[wr_q]  = 1'b1;
        mem_d[wr1_s]   = push1;
        valid_d[wr1_s] = 1'b1;
      end
      default: mem_d = mem_q;
    endcase
    rd_d    = rd_q + PTR_W'(pop_cnt);
    wr_d    = wr_q + PTR_W'(push_cnt);
    count_d = count_q + CNT_W'(push_cnt) - CNT_W'(pop_cnt);
  end

  // Pointer, occupancy and valid state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Entry storage; contents are only meaningful where the slot is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/wb_drain.sv
// Write-back drain buffer: merges two producers into a FIFO and drains up to
// two entries per cycle onto a dual-write register file port pair.
// Optional feature macro: WB_DRAIN_BYPASS_EN (same-cycle forwarding when empty).
module wb_drain import wb_pkg::*; #(
  parameter int DATAWIDTH = 32,
  parameter int DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   p0_valid,
  output logic                   p0_ready,
  input  logic [REG_AW-1:0]      p0_reg,
  input  logic [DATAWIDTH-1:0]   p0_data,
  input  logic                   p1_valid,
  output logic                   p1_ready,
  input  logic [REG_AW-1:0]      p1_reg,
  input  logic [DATAWIDTH-1:0]   p1_data,
  input  logic                   stall,
  output logic                   write,
  output logic [REG_AW-1:0]      writeReg1,
  output logic [REG_AW-1:0]      writeReg2,
  output logic [DATAWIDTH-1:0]   writeData1,
  output logic [DATAWIDTH-1:0]   writeData2,
  output logic [NUM_REGS-1:0]    pending,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);
  localparam logic [CNT_W-1:0] LIM0    = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] LIM1    = CNT_W'(DEPTH - 2);
`ifdef WB_DRAIN_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  wb_entry_t               p0_ent_s, p1_ent_s;
  wb_entry_t               head0_s, head1_s;
  wb_entry_t               push0_s, push1_s;
  wb_entry_t               src0_s, src1_s;
  wb_entry_t               port1_s, port2_s;
  wb_entry_t               drive1_s, drive2_s;
  wb_entry_t               last1_q, last1_d, last2_q, last2_d;
  logic [CNT_W-1:0]        fifo_cnt_s;
  logic [DEPTH-1:0]        fifo_valid_s;
  logic [DEPTH*REG_AW-1:0] fifo_regs_s;
  logic [1:0]              push_cnt_s, pop_cnt_s, nsrc_s;
  logic                    acc0_s, acc1_s, bypass_s, write_s;
  logic [NUM_REGS-1:0]     pending_s;

  assign p0_ent_s = '{rd: p0_reg, data: WB_DATA_W'(p0_data)};
  assign p1_ent_s = '{rd: p1_reg, data: WB_DATA_W'(p1_data)};

  // Readiness looks only at the registered occupancy; this cycle's drain is not credited.
  assign p0_ready = !reset && (fifo_cnt_s <= LIM0);
  assign p1_ready = !reset && (fifo_cnt_s <= LIM1);
  assign acc0_s   = p0_valid && p0_ready;
  assign acc1_s   = p1_valid && p1_ready;

  wb_fifo2 #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_cnt (push_cnt_s),
    .push0    (push0_s),
    .push1    (push1_s),
    .pop_cnt  (pop_cnt_s),
    .head0    (head0_s),
    .head1    (head1_s),
    .count    (fifo_cnt_s),
    .valid    (fifo_valid_s),
    .regs     (fifo_regs_s)
  );

  // Choose the drain source (buffer heads or bypassed producers) and form the write pair.
  always_comb begin
    push1_s    = p1_ent_s;
    push_cnt_s = {1'b0, acc0_s} + {1'b0, acc1_s};
    pop_cnt_s  = 2'd0;
    port1_s    = head0_s;
    port2_s    = head0_s;
    bypass_s   = BYPASS_EN && (fifo_cnt_s == '0) && !stall && !reset;

    // A lone p1 takes the first free slot so the buffer stays gap-free.
    if (acc0_s) begin
      push0_s = p0_ent_s;
    end else begin
      push0_s = p1_ent_s;
    end

    if (bypass_s) begin
      src0_s     = push0_s;
      src1_s     = p1_ent_s;
      nsrc_s     = push_cnt_s;
      push_cnt_s = 2'd0;
    end else begin
      src0_s = head0_s;
      src1_s = head1_s;
      if (fifo_cnt_s >= CNT_TWO) begin
        nsrc_s = 2'd2;
      end else if (fifo_cnt_s == CNT_ONE) begin
        nsrc_s = 2'd1;
      end else begin
        nsrc_s = 2'd0;
      end
    end

    write_s = !reset && !stall && (nsrc_s != 2'd0);

    // Same destination: the younger value wins and the older write is dropped.
    case (nsrc_s)
      2'd2: begin
        if (src0_s.rd == src1_s.rd) begin
          port1_s = src1_s;
          port2_s = src1_s;
        end else begin
          port1_s = src0_s;
          port2_s = src1_s;
        end
      end
      default: begin
        port1_s = src0_s;
        port2_s = src0_s;
      end
    endcase

    if (write_s && !bypass_s) begin
      pop_cnt_s = nsrc_s;
    end else begin
      pop_cnt_s = 2'd0;
    end
  end

  // Write ports carry the new pair while writing, otherwise the last pair written.
  always_comb begin
    if (write_s) begin
      drive1_s = port1_s;
      drive2_s = port2_s;
    end else begin
      drive1_s = last1_q;
      drive2_s = last2_q;
    end
    last1_d = drive1_s;
    last2_d = drive2_s;
  end

  // Remember the last driven write-port values.
  always_ff @(posedge clk) begin
    if (reset) begin
      last1_q <= '0;
      last2_q <= '0;
    end else begin
      last1_q <= last1_d;
      last2_q <= last2_d;
    end
  end

  // Decode buffered destinations; bypassed entries never enter the buffer.
  always_comb begin
    pending_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_valid_s[i]) begin
        pending_s = pending_s | reg_onehot(fifo_regs_s[i*REG_AW +: REG_AW]);
      end else begin
        pending_s = pending_s;
      end
    end
  end

  assign write      = write_s;
  assign writeReg1  = drive1_s.rd;
  assign writeReg2  = drive2_s.rd;
  assign writeData1 = drive1_s.data[DATAWIDTH-1:0];
  assign writeData2 = drive2_s.data[DATAWIDTH-1:0];
  assign pending    = pending_s;
  assign count      = fifo_cnt_s;

  // Zero-extension bits of the shared entry type are carried but never driven out.
  if (DATAWIDTH < WB_DATA_W) begin : g_pad
    logic pad_unused_s;
    assign pad_unused_s = ^{drive1_s.data[WB_DATA_W-1:DATAWIDTH],
                            drive2_s.data[WB_DATA_W-1:DATAWIDTH]};
  end

endmodule

// File: tb/tb_wb_drain.sv
// Self-checking bench for wb_drain. Define WB_DRAIN_BYPASS_EN to check the bypass build.
module tb_wb_drain;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
`ifdef WB_DRAIN_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          p0_valid, p0_ready, p1_valid, p1_ready, stall, write;
  logic [3:0]    p0_reg, p1_reg, writeReg1, writeReg2;
  logic [DW-1:0] p0_data, p1_data, writeData1, writeData2;
  logic [15:0]   pending;
  logic [2:0]    count;
  logic [72:0]   wp;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  wb_drain #(.DATAWIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_reg(p0_reg), .p0_data(p0_data),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_reg(p1_reg), .p1_data(p1_data),
    .stall(stall), .write(write),
    .writeReg1(writeReg1), .writeReg2(writeReg2),
    .writeData1(writeData1), .writeData2(writeData2),
    .pending(pending), .count(count)
  );

  assign wp = {write, writeReg1, writeData1, writeReg2, writeData2};

  task automatic drive(input logic v0, input logic [3:0] r0, input logic [31:0] d0,
                       input logic v1, input logic [3:0] r1, input logic [31:0] d1,
                       input logic st);
    p0_valid = v0; p0_reg = r0; p0_data = d0;
    p1_valid = v1; p1_reg = r1; p1_data = d1;
    stall    = st;
  endtask

  task automatic idle(input logic st);
    drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, st);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; idle(1'b0);
    @(negedge clk);
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); reset = 1'b1; drive(1'b1, 4'd3, 32'h5, 1'b1, 4'd4, 32'h6, 1'b0); #1;
    tests_run++;
    if ({p0_ready, p1_ready, write} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_ready: got %b want 000", {p0_ready, p1_ready, write});
    end
    @(negedge clk); idle(1'b0); #1;
    tests_run++;
    if ({count, pending, wp} !== {3'd0, 16'h0, 73'd0}) begin
      tests_failed++; $display("FAIL reset_state: got %h want 0", {count, pending, wp});
    end
    @(negedge clk); reset = 1'b0; #1;
    tests_run++;
    if ({p0_ready, p1_ready, count, pending, write} !== {2'b11, 3'd0, 16'h0, 1'b0}) begin
      tests_failed++; $display("FAIL reset_release: got %h want %h",
        {p0_ready, p1_ready, count, pending, write}, {2'b11, 3'd0, 16'h0, 1'b0});
    end
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk); drive(1'b1, 4'd3, 32'h11, 1'b0, 4'd0, 32'd0, BYP);
    @(negedge clk); idle(1'b0); #1;
    tests_run++;
    if (wp !== {1'b1, 4'd3, 32'h11, 4'd3, 32'h11}) begin
      tests_failed++; $display("FAIL single_write: got %h want %h", wp, {1'b1, 4'd3, 32'h11, 4'd3, 32'h11});
    end
    tests_run++;
    if ({pending, count} !== {16'h0008, 3'd1}) begin
      tests_failed++; $display("FAIL single_pending: got %h/%0d want 0008/1", pending, count);
    end
    @(negedge clk); idle(1'b0); #1;
    tests_run++;
    if ({write, writeReg1, writeData1, count, pending} !== {1'b0, 4'd3, 32'h11, 3'd0, 16'h0}) begin
      tests_failed++; $display("FAIL single_hold: got %h want %h",
        {write, writeReg1, writeData1, count, pending}, {1'b0, 4'd3, 32'h11, 3'd0, 16'h0});
    end
  endtask

  task automatic test_pair();
    @(negedge clk); drive(1'b1, 4'd2, 32'hA, 1'b1, 4'd5, 32'hB, BYP);
    @(negedge clk); idle(1'b0); #1;
    tests_run++;
    if (wp !== {1'b1, 4'd2, 32'hA, 4'd5, 32'hB}) begin
      tests_failed++; $display("FAIL pair_write: got %h want %h", wp, {1'b1, 4'd2, 32'hA, 4'd5, 32'hB});
    end
    tests_run++;
    if ({count, pending} !== {3'd2, 16'h0024}) begin
      tests_failed++; $display("FAIL pair_count: got %0d/%h want 2/0024", count, pending);
    end
    @(negedge clk); idle(1'b0); #1;
    tests_run++;
    if ({count, write} !== {3'd0, 1'b0}) begin
      tests_failed++; $display("FAIL pair_drained: got count %0d write %b want 0 0", count, write);
    end
  endtask

  task automatic test_merge();
    @(negedge clk); drive(1'b1, 4'd7, 32'h1, 1'b1, 4'd7, 32'h2, BYP);
    @(negedge clk); idle(1'b0); #1;
    tests_run++;
    if (wp !== {1'b1, 4'd7, 32'h2, 4'd7, 32'h2}) begin
      tests_failed++; $display("FAIL merge_write: got %h want %h", wp, {1'b1, 4'd7, 32'h2, 4'd7, 32'h2});
    end
    @(negedge clk); idle(1'b0); #1;
    tests_run++;
    if ({write, writeData1, writeData2, count} !== {1'b0, 32'h2, 32'h2, 3'd0}) begin
      tests_failed++; $display("FAIL merge_after: got %h want %h",
        {write, writeData1, writeData2, count}, {1'b0, 32'h2, 32'h2, 3'd0});
    end
  endtask

  task automatic test_stall_full();
    @(negedge clk); drive(1'b1, 4'd1, 32'h10, 1'b1, 4'd2, 32'h20, 1'b1);
    @(negedge clk); drive(1'b1, 4'd3, 32'h30, 1'b1, 4'd4, 32'h40, 1'b1); #1;
    tests_run++;
    if ({p0_ready, p1_ready, write, count} !== {3'b110, 3'd2}) begin
      tests_failed++; $display("FAIL stall_half: got %h want %h", {p0_ready, p1_ready, write, count}, {3'b110, 3'd2});
    end
    @(negedge clk); idle(1'b1); #1;
    tests_run++;
    if ({p0_ready, p1_ready, write, count, pending} !== {3'b000, 3'd4, 16'h001E}) begin
      tests_failed++; $display("FAIL stall_full: got %h want %h",
        {p0_ready, p1_ready, write, count, pending}, {3'b000, 3'd4, 16'h001E});
    end
    // Release stall while offering entries that must be refused (drain not credited).
    @(negedge clk); drive(1'b1, 4'd9, 32'h99, 1'b1, 4'd9, 32'h99, 1'b0); #1;
    tests_run++;
    if ({wp, p0_ready, p1_ready} !== {1'b1, 4'd1, 32'h10, 4'd2, 32'h20, 2'b00}) begin
      tests_failed++; $display("FAIL stall_drain1: got %h want %h",
        {wp, p0_ready, p1_ready}, {1'b1, 4'd1, 32'h10, 4'd2, 32'h20, 2'b00});
    end
    @(negedge clk); idle(1'b0); #1;
    tests_run++;
    if ({wp, count} !== {1'b1, 4'd3, 32'h30, 4'd4, 32'h40, 3'd2}) begin
      tests_failed++; $display("FAIL stall_drain2: got %h want %h", {wp, count}, {1'b1, 4'd3, 32'h30, 4'd4, 32'h40, 3'd2});
    end
    @(negedge clk); idle(1'b0); #1;
    tests_run++;
    if ({write, count, pending} !== {1'b0, 3'd0, 16'h0}) begin
      tests_failed++; $display("FAIL stall_empty: got %h want 0", {write, count, pending});
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); drive(1'b1, 4'd4, 32'h44, 1'b1, 4'd5, 32'h55, 1'b1);
    @(negedge clk); drive(1'b1, 4'd6, 32'h66, 1'b0, 4'd0, 32'd0, 1'b1);
    @(negedge clk); idle(1'b1); #1;
    tests_run++;
    if ({count, pending} !== {3'd3, 16'h0070}) begin
      tests_failed++; $display("FAIL midrst_fill: got %0d/%h want 3/0070", count, pending);
    end
    @(negedge clk); reset = 1'b1; drive(1'b1, 4'd8, 32'h88, 1'b1, 4'd9, 32'h99, 1'b0); #1;
    tests_run++;
    if ({p0_ready, p1_ready, write} !== 3'b000) begin
      tests_failed++; $display("FAIL midrst_ready: got %b want 000", {p0_ready, p1_ready, write});
    end
    @(negedge clk); reset = 1'b0; idle(1'b0); #1;
    tests_run++;
    if ({count, pending, wp} !== {3'd0, 16'h0, 73'd0}) begin
      tests_failed++; $display("FAIL midrst_clear: got %h want 0", {count, pending, wp});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      tests_run++;
      if (write !== 1'b0) begin
        tests_failed++; $display("FAIL midrst_nowrite: cycle %0d got write %b want 0", k, write);
      end
    end
  endtask

`ifdef WB_DRAIN_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    @(negedge clk); drive(1'b1, 4'd1, 32'h9, 1'b0, 4'd0, 32'd0, 1'b0); #1;
    tests_run++;
    if ({wp, count, pending} !== {1'b1, 4'd1, 32'h9, 4'd1, 32'h9, 3'd0, 16'h0}) begin
      tests_failed++; $display("FAIL bypass_single: got %h want %h",
        {wp, count, pending}, {1'b1, 4'd1, 32'h9, 4'd1, 32'h9, 3'd0, 16'h0});
    end
    @(negedge clk); drive(1'b1, 4'd6, 32'h61, 1'b1, 4'd6, 32'h62, 1'b0); #1;
    tests_run++;
    if ({wp, count} !== {1'b1, 4'd6, 32'h62, 4'd6, 32'h62, 3'd0}) begin
      tests_failed++; $display("FAIL bypass_merge: got %h want %h", {wp, count}, {1'b1, 4'd6, 32'h62, 4'd6, 32'h62, 3'd0});
    end
    @(negedge clk); idle(1'b0); #1;
    tests_run++;
    if ({write, count} !== {1'b0, 3'd0}) begin
      tests_failed++; $display("FAIL bypass_after: got %b/%0d want 0/0", write, count);
    end
  endtask
`else
  task automatic test_latency();
    do_reset();
    @(negedge clk); drive(1'b1, 4'd1, 32'h9, 1'b0, 4'd0, 32'd0, 1'b0); #1;
    tests_run++;
    if ({write, count} !== {1'b0, 3'd0}) begin
      tests_failed++; $display("FAIL latency_same: got %b/%0d want 0/0", write, count);
    end
    @(negedge clk); idle(1'b0); #1;
    tests_run++;
    if ({wp, count} !== {1'b1, 4'd1, 32'h9, 4'd1, 32'h9, 3'd1}) begin
      tests_failed++; $display("FAIL latency_next: got %h want %h", {wp, count}, {1'b1, 4'd1, 32'h9, 4'd1, 32'h9, 3'd1});
    end
  endtask
`endif

  // Random traffic against a queue model; also compares the register file
  // image built from observed writes with the program-order last value per register.
  task automatic test_random();
    ent_t        q[$];
    ent_t        src[$];
    ent_t        e1, e2, l1, l2;
    logic [31:0] ref_rf [16];
    logic [31:0] dut_rf [16];
    logic        v0, v1, st, a0, a1, byp, ew;
    logic [3:0]  r0, r1;
    logic [31:0] d0, d1;
    logic [15:0] ep;
    do_reset();
    l1 = '{rd: 4'd0, data: 32'd0};
    l2 = '{rd: 4'd0, data: 32'd0};
    for (int i = 0; i < 16; i++) begin
      ref_rf[i] = 32'd0;
      dut_rf[i] = 32'd0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc < 340) begin
        v0 = 1'($urandom_range(0, 1)); v1 = 1'($urandom_range(0, 1));
        r0 = 4'($urandom_range(0, 5)); r1 = 4'($urandom_range(0, 5));
        d0 = $urandom;                 d1 = $urandom;
        st = ($urandom_range(0, 3) == 0);
      end else begin
        v0 = 1'b0; v1 = 1'b0; r0 = 4'd0; r1 = 4'd0; d0 = 32'd0; d1 = 32'd0; st = 1'b0;
      end
      @(negedge clk); drive(v0, r0, d0, v1, r1, d1, st); #1;
      a0  = v0 && (q.size() <= DEPTH - 1);
      a1  = v1 && (q.size() <= DEPTH - 2);
      byp = BYP && (q.size() == 0) && !st;
      src.delete();
      if (byp) begin
        if (a0) src.push_back('{rd: r0, data: d0});
        if (a1) src.push_back('{rd: r1, data: d1});
      end else begin
        for (int k = 0; k < q.size() && k < 2; k++) src.push_back(q[k]);
      end
      ew = !st && (src.size() > 0);
      if (!ew) begin
        e1 = l1; e2 = l2;
      end else if (src.size() == 2 && src[0].rd == src[1].rd) begin
        e1 = src[1]; e2 = src[1];
      end else if (src.size() == 2) begin
        e1 = src[0]; e2 = src[1];
      end else begin
        e1 = src[0]; e2 = src[0];
      end
      ep = 16'h0;
      foreach (q[k]) ep[q[k].rd] = 1'b1;

      tests_run++;
      if ({p0_ready, p1_ready} !== {q.size() <= DEPTH - 1, q.size() <= DEPTH - 2}) begin
        tests_failed++; $display("FAIL rnd_ready: cyc %0d got %b want %b", cyc,
          {p0_ready, p1_ready}, {q.size() <= DEPTH - 1, q.size() <= DEPTH - 2});
      end
      tests_run++;
      if (wp !== {ew, e1.rd, e1.data, e2.rd, e2.data}) begin
        tests_failed++; $display("FAIL rnd_write: cyc %0d got %h want %h", cyc, wp, {ew, e1.rd, e1.data, e2.rd, e2.data});
      end
      tests_run++;
      if ({count, pending} !== {3'(q.size()), ep}) begin
        tests_failed++; $display("FAIL rnd_occupancy: cyc %0d got %0d/%h want %0d/%h", cyc, count, pending, q.size(), ep);
      end
      if (write === 1'b1) begin
        dut_rf[writeReg1] = writeData1;
        dut_rf[writeReg2] = writeData2;
      end
      @(posedge clk);
      l1 = e1; l2 = e2;
      if (ew && !byp) begin
        repeat (src.size()) void'(q.pop_front());
      end
      if (!byp) begin
        if (a0) q.push_back('{rd: r0, data: d0});
        if (a1) q.push_back('{rd: r1, data: d1});
      end
      if (a0) ref_rf[r0] = d0;
      if (a1) ref_rf[r1] = d1;
    end
    for (int r = 0; r < 16; r++) begin
      tests_run++;
      if (dut_rf[r] !== ref_rf[r]) begin
        tests_failed++; $display("FAIL rnd_regfile: r%0d got %h want %h", r, dut_rf[r], ref_rf[r]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle(1'b0);
    test_reset();
    test_single();
    test_pair();
    test_merge();
    test_stall_full();
    test_reset_mid();
`ifdef WB_DRAIN_BYPASS_EN
    test_bypass();
`else
    test_latency();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
